mem_arbiter: RTL

Shares one single-port, word-wide memory bus between the core's instruction-fetch port and its data-access port. Sits directly below `core`: it consumes `inst_re`/`inst_addr` and `data_access`/`data_we`/`data_addr`/`wr_data`, and produces `inst`/`rd_data` plus completion strobes. It serialises requests, holds them stable on the bus until the memory acknowledges, and optionally aborts hung accesses.

---
 rtl/raptorv_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/arb_timeout.sv | 38 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/raptorv_pkg.sv
// rtl/raptorv_pkg.sv - shared types and constants for the memory arbiter slice
//
// Purpose: arbiter FSM state encoding, machine word width and the registered
// bus request record shared by mem_arbiter and its interface.
// Ports: none (package).
package raptorv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Everything that must stay stable on the bus while mem_req is high.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - single-port word-wide memory bus between arbiter and memory
//
// Purpose: groups the memory-side request/acknowledge handshake.
// Signals:
//   mem_req   request, held until mem_ack
//   mem_we    1 = write, 0 = read
//   mem_addr  word address
//   mem_wdata write data
//   mem_ack   one-cycle completion from memory
//   mem_rdata read data, valid with mem_ack
// Modports: master (arbiter side), slave (memory side).
interface mem_arbiter_if;
  import raptorv_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/arb_timeout.sv
// rtl/arb_timeout.sv - wait counter and expiry compare for hung bus accesses
//
// Purpose: counts cycles a request waits without acknowledge and flags the
// cycle in which the count would reach TIMEOUT.
// Ports:
//   clk, rst_l  clock, asynchronous active-low reset
//   clear       restart the count (asserted on grant)
//   active      request high and no acknowledge this cycle
//   expire      this waiting cycle is the TIMEOUT-th one
module arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  input  logic active,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the last permitted waiting cycle so mem_req is high for exactly
  // TIMEOUT cycles before it drops.
  assign expire = active && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-port memory bus
//
// Purpose: serialises instruction-fetch and data requests onto one memory
// bus, alternating on ties, holding the request stable until mem_ack.
// Optional feature macro: MEM_ARBITER_TIMEOUT_EN (abort after TIMEOUT cycles).
// Ports:
//   clk, rst_l                                   clock, async active-low reset
//   inst_re, inst_addr -> inst, inst_vld         fetch port
//   data_access, data_we, data_addr, wr_data
//     -> rd_data, data_vld                       data port
//   bus (mem_arbiter_if.master)                  memory bus
//   bus_err                                      one-cycle abort pulse
module mem_arbiter
  import raptorv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             inst_re,
  input  logic [XLEN-1:0]  inst_addr,
  output logic [XLEN-1:0]  inst,
  output logic             inst_vld,
  input  logic             data_access,
  input  logic             data_we,
  input  logic [XLEN-1:0]  data_addr,
  input  logic [XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]  rd_data,
  output logic             data_vld,
  mem_arbiter_if.master    bus,
  output logic             bus_err
);

  arb_state_t      state;
  mem_req_t        req_q;
  logic            mem_req_q;
  logic            last_inst;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] rd_q;
  logic            inst_vld_q;
  logic            data_vld_q;
  logic            err_q;

  logic inst_pend;
  logic data_pend;
  logic grant_data;
  logic grant_inst;
  logic expire;

  // A port whose completion pulse is showing is still holding its old
  // request this cycle, so it is masked; the other port may be granted.
  assign inst_pend  = inst_re && !inst_vld_q;
  assign data_pend  = data_access && !data_vld_q;
  assign grant_data = (state == IDLE) && data_pend && (!inst_pend || last_inst);
  assign grant_inst = (state == IDLE) && inst_pend && !grant_data;

`ifdef MEM_ARBITER_TIMEOUT_EN
  arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_l  (rst_l),
    .clear  (grant_data || grant_inst),
    .active (mem_req_q && !bus.mem_ack),
    .expire (expire)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign expire         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      last_inst  <= 1'b1;
      req_q      <= '0;
      mem_req_q  <= 1'b0;
      inst_q     <= '0;
      rd_q       <= '0;
      inst_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inst_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            state       <= DATA;
            last_inst   <= 1'b0;
            req_q.we    <= data_we;
            req_q.addr  <= data_addr;
            req_q.wdata <= wr_data;
            mem_req_q   <= 1'b1;
          end else if (grant_inst) begin
            state       <= INST;
            last_inst   <= 1'b1;
            req_q.we    <= 1'b0;
            req_q.addr  <= inst_addr;
            req_q.wdata <= '0;
            mem_req_q   <= 1'b1;
          end
        end
        INST: begin
          // An acknowledge coinciding with expiry completes normally.
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            inst_vld_q <= 1'b1;
            inst_q     <= bus.mem_rdata;
            state      <= IDLE;
          end else if (expire) begin
            mem_req_q  <= 1'b0;
            inst_vld_q <= 1'b1;
            err_q      <= 1'b1;
            inst_q     <= '0;
            state      <= IDLE;
          end
        end
        DATA: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            data_vld_q <= 1'b1;
            if (!req_q.we) begin
              rd_q <= bus.mem_rdata;
            end
            state <= IDLE;
          end else if (expire) begin
            mem_req_q  <= 1'b0;
            data_vld_q <= 1'b1;
            err_q      <= 1'b1;
            rd_q       <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = req_q.we;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign inst          = inst_q;
  assign inst_vld      = inst_vld_q;
  assign rd_data       = rd_q;
  assign data_vld      = data_vld_q;
  assign bus_err       = err_q;

endmodule
